// File: rtl/bypass_history_nd_pkg.sv
// Shared types and constants for the multi-depth operand bypass network.
// Holds the bypass packet layout and the hit-stage width / depth legality helpers.
package bypass_history_nd_pkg;

  localparam int ISSUE_WIDTH = 4;
  localparam int PHYS_W      = 7;
  localparam int DATA_W      = 32;

  typedef struct packed {
    logic [PHYS_W-1:0] tag;
    logic              valid;
    logic [DATA_W-1:0] data;
  } bypass_pkt_t;

  // Codes: 0 = register file, 1 = live, k+2 = history entry k.
  function automatic int hs_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 1) && (depth <= 4);
  endfunction

endpackage

// File: rtl/bypass_history_nd_if.sv
// Bundle of bypass packets, operand requests and resolved operands.
interface bypass_history_nd_if
  import bypass_history_nd_pkg::*;
#(
  parameter int NUM_LANES = ISSUE_WIDTH,
  parameter int NUM_SRC   = 2,
  parameter int HS_W      = 2
);

  // Handshake: no backpressure. src_valid qualifies a request in the cycle it is
  // presented; valid reports that request one cycle later. flush drops requests
  // and history, hold freezes the result registers.
  bypass_pkt_t [NUM_LANES-1:0]         bypass_packet;
  logic                                flush;
  logic                                hold;
  logic [NUM_SRC-1:0]                  src_valid;
  logic [NUM_SRC-1:0][PHYS_W-1:0]      phy_src;
  logic [NUM_SRC-1:0][DATA_W-1:0]      rf_data;
  logic [NUM_SRC-1:0][DATA_W-1:0]      data;
  logic [NUM_SRC-1:0]                  valid;
  logic [NUM_SRC-1:0][HS_W-1:0]        hit_stage;

  modport master (
    output bypass_packet, flush, hold, src_valid, phy_src, rf_data,
    input  data, valid, hit_stage
  );

  modport slave (
    input  bypass_packet, flush, hold, src_valid, phy_src, rf_data,
    output data, valid, hit_stage
  );

endinterface

// File: rtl/bypass_history_nd_match_stage.sv
// One stage's lanes compared against one source tag; highest matching lane wins.
module bypass_history_nd_match_stage
  import bypass_history_nd_pkg::*;
#(
  parameter int NUM_LANES = ISSUE_WIDTH
) (
  input  bypass_pkt_t [NUM_LANES-1:0] pkts,
  input  logic [PHYS_W-1:0]           tag,
  output logic                        hit,
  output logic [DATA_W-1:0]           data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (pkts[l].valid && (pkts[l].tag == tag)) begin
        hit  = 1'b1;
        data = pkts[l].data;
      end
    end
  end

endmodule

// File: rtl/bypass_history_nd.sv
// Multi-source operand bypass over live packets plus a DEPTH-cycle packet history,
// with register-file fallback and registered, holdable, flushable results.
module bypass_history_nd
  import bypass_history_nd_pkg::*;
#(
  parameter int NUM_LANES = ISSUE_WIDTH,
  parameter int DEPTH     = 2,
  parameter int NUM_SRC   = 2,
  parameter int HS_W      = hs_width(DEPTH)
) (
  input logic               clk,
  input logic               reset,
  bypass_history_nd_if.slave bus
);

  typedef bypass_pkt_t [NUM_LANES-1:0] lane_set_t;

  if (!depth_legal(DEPTH)) begin : g_depth_check
    $error("bypass_history_nd: DEPTH must be within 1..4");
  end

  lane_set_t hist  [DEPTH];
  lane_set_t stage [DEPTH+1];

  // The history ages every cycle, independent of hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else begin
      hist[0] <= bus.bypass_packet;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  assign stage[0] = bus.bypass_packet;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign stage[k+1] = hist[k];
  end

  logic              hit      [NUM_SRC][DEPTH+1];
  logic [DATA_W-1:0] hit_data [NUM_SRC][DEPTH+1];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    for (genvar j = 0; j <= DEPTH; j++) begin : g_match
      bypass_history_nd_match_stage #(.NUM_LANES(NUM_LANES)) u_match (
        .pkts (stage[j]),
        .tag  (bus.phy_src[s]),
        .hit  (hit[s][j]),
        .data (hit_data[s][j])
      );
    end
  end

  logic [DATA_W-1:0] sel_data [NUM_SRC];
  logic [HS_W-1:0]   sel_hs   [NUM_SRC];

  // Walk oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      sel_data[s] = bus.rf_data[s];
      sel_hs[s]   = '0;
      for (int j = DEPTH; j >= 0; j--) begin
        if (hit[s][j]) begin
          sel_data[s] = hit_data[s][j];
          sel_hs[s]   = HS_W'(j + 1);
        end
      end
    end
  end

  logic [NUM_SRC-1:0][DATA_W-1:0] data_q;
  logic [NUM_SRC-1:0]             valid_q;
  logic [NUM_SRC-1:0][HS_W-1:0]   hs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= '0;
      hs_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (!bus.hold) begin
      valid_q <= bus.src_valid;
      for (int s = 0; s < NUM_SRC; s++) begin
        data_q[s] <= sel_data[s];
        hs_q[s]   <= sel_hs[s];
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.hit_stage = hs_q;

endmodule

// File: tb/tb_bypass_history_nd.sv
// Directed and randomized checks of bypass_history_nd against a queue-based history model.
module tb_bypass_history_nd;
  import bypass_history_nd_pkg::*;

  localparam int NL    = 4;
  localparam int DEPTH = 2;
  localparam int NS    = 2;
  localparam int HS_W  = 2;

  typedef bypass_pkt_t [NL-1:0] lane_set_t;

  logic clk;
  logic reset;

  bypass_history_nd_if #(.NUM_LANES(NL), .NUM_SRC(NS), .HS_W(HS_W)) bif ();

  bypass_history_nd #(.NUM_LANES(NL), .DEPTH(DEPTH), .NUM_SRC(NS), .HS_W(HS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: packets of past cycles, youngest at the front.
  lane_set_t   hist_m [$];
  logic [31:0] exp_data  [NS];
  logic        exp_valid [NS];
  logic [1:0]  exp_hs    [NS];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_outputs(input string name);
    for (int s = 0; s < NS; s++) begin
      check($sformatf("%s_data%0d", name, s), bif.data[s], exp_data[s]);
      check($sformatf("%s_valid%0d", name, s), 32'(bif.valid[s]), 32'(exp_valid[s]));
      check($sformatf("%s_hs%0d", name, s), 32'(bif.hit_stage[s]), 32'(exp_hs[s]));
    end
  endtask

  task automatic model_reset();
    hist_m.delete();
    for (int s = 0; s < NS; s++) begin
      exp_data[s] = '0; exp_valid[s] = 1'b0; exp_hs[s] = '0;
    end
  endtask

  // Youngest age first; within an age, highest lane first.
  function automatic logic [33:0] resolve(input lane_set_t live, input logic [6:0] tag,
                                          input logic [31:0] rf);
    lane_set_t sets [$];
    sets.push_back(live);
    foreach (hist_m[i]) sets.push_back(hist_m[i]);
    for (int age = 0; age < sets.size(); age++)
      for (int l = NL - 1; l >= 0; l--)
        if (sets[age][l].valid && sets[age][l].tag == tag)
          return {2'(age + 1), sets[age][l].data};
    return {2'b00, rf};
  endfunction

  task automatic clear_inputs();
    for (int l = 0; l < NL; l++) begin
      bif.bypass_packet[l].tag   = 7'($urandom);
      bif.bypass_packet[l].valid = 1'b0;
      bif.bypass_packet[l].data  = $urandom;
    end
    bif.flush = 1'b0;
    bif.hold  = 1'b0;
    for (int s = 0; s < NS; s++) begin
      bif.src_valid[s] = 1'b0;
      bif.phy_src[s]   = 7'($urandom);
      bif.rf_data[s]   = $urandom;
    end
  endtask

  task automatic set_pkt(input int l, input logic [6:0] tag, input logic [31:0] d);
    bif.bypass_packet[l].tag   = tag;
    bif.bypass_packet[l].valid = 1'b1;
    bif.bypass_packet[l].data  = d;
  endtask

  task automatic req(input int s, input logic [6:0] tag, input logic [31:0] rf);
    bif.src_valid[s] = 1'b1;
    bif.phy_src[s]   = tag;
    bif.rf_data[s]   = rf;
  endtask

  task automatic step(input string name);
    logic [33:0] r;
    lane_set_t   live;
    live = bif.bypass_packet;
    for (int s = 0; s < NS; s++) begin
      r = resolve(live, bif.phy_src[s], bif.rf_data[s]);
      if (bif.flush) exp_valid[s] = 1'b0;
      else if (!bif.hold) begin
        exp_valid[s] = bif.src_valid[s];
        exp_data[s]  = r[31:0];
        exp_hs[s]    = r[33:32];
      end
    end
    if (bif.flush) hist_m.delete();
    else begin
      hist_m.push_front(live);
      if (hist_m.size() > DEPTH) void'(hist_m.pop_back());
    end
    @(posedge clk);
    #1;
    check_outputs(name);
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    clear_inputs();

    // Reset held for three edges with arbitrary inputs.
    for (int i = 0; i < 3; i++) begin
      set_pkt(i, 7'($urandom), $urandom);
      req(0, 7'($urandom), $urandom);
      bif.flush = 1'($urandom);
      @(posedge clk);
      #1;
      check_outputs("reset");
    end
    #2 reset = 1'b1;

    // Basic bypass from each stage.
    clear_inputs();
    set_pkt(2, 7'h15, 32'hAAAA);
    req(0, 7'h15, 32'h1111);
    step("live");
    check("tp_live_data", bif.data[0], 32'hAAAA);
    check("tp_live_hs", 32'(bif.hit_stage[0]), 32'd1);
    clear_inputs(); req(0, 7'h15, 32'h1111); step("h0");
    check("tp_h0_hs", 32'(bif.hit_stage[0]), 32'd2);
    clear_inputs(); req(0, 7'h15, 32'h1111); step("h1");
    check("tp_h1_data", bif.data[0], 32'hAAAA);
    check("tp_h1_hs", 32'(bif.hit_stage[0]), 32'd3);
    clear_inputs(); req(0, 7'h15, 32'h1111); step("expired");
    check("tp_rf_data", bif.data[0], 32'h1111);
    check("tp_rf_hs", 32'(bif.hit_stage[0]), 32'd0);

    // Age priority: younger broadcast of the same tag wins.
    clear_inputs(); set_pkt(0, 7'h20, 32'h1); step("age_a");
    clear_inputs(); set_pkt(1, 7'h20, 32'h2); req(0, 7'h20, 32'hF); step("age_b");
    check("tp_age_live", bif.data[0], 32'h2);
    clear_inputs(); req(0, 7'h20, 32'hF); step("age_c");
    check("tp_age_hist", bif.data[0], 32'h2);
    check("tp_age_hs", 32'(bif.hit_stage[0]), 32'd2);

    // Lane priority inside one stage.
    clear_inputs();
    set_pkt(0, 7'h07, 32'hB0);
    set_pkt(3, 7'h07, 32'hB3);
    req(1, 7'h07, 32'hF);
    step("lane");
    check("tp_lane", bif.data[1], 32'hB3);

    // Flush drops the request and the history.
    clear_inputs(); set_pkt(1, 7'h09, 32'h99); step("fl_a");
    clear_inputs(); bif.flush = 1'b1; req(0, 7'h09, 32'h1234); step("fl_b");
    check("tp_flush_valid", 32'(bif.valid[0]), 32'd0);
    clear_inputs(); req(0, 7'h09, 32'h4321); step("fl_c");
    check("tp_flush_rf", bif.data[0], 32'h4321);
    check("tp_flush_hs", 32'(bif.hit_stage[0]), 32'd0);

    // Hold freezes outputs while history keeps aging.
    clear_inputs(); set_pkt(0, 7'h30, 32'h55); req(0, 7'h30, 32'h0); step("hold_set");
    check("tp_hold_set", bif.data[0], 32'h55);
    clear_inputs(); bif.hold = 1'b1; set_pkt(2, 7'h31, 32'h77); req(0, 7'h31, 32'h0);
    step("hold0");
    for (int i = 1; i < 4; i++) begin
      clear_inputs(); bif.hold = 1'b1;
      req(0, 7'h31, $urandom); req(1, 7'($urandom), $urandom);
      step("hold");
      check("tp_hold_data", bif.data[0], 32'h55);
      check("tp_hold_valid", 32'(bif.valid[0]), 32'd1);
    end
    clear_inputs(); req(0, 7'h31, 32'hCAFE); step("hold_aged");
    check("tp_hold_aged", 32'(bif.hit_stage[0]), 32'd0);

    // Randomized traffic over a narrow tag range so stages collide often.
    for (int i = 0; i < 300; i++) begin
      for (int l = 0; l < NL; l++) begin
        bif.bypass_packet[l].tag   = 7'($urandom_range(0, 7));
        bif.bypass_packet[l].valid = 1'($urandom_range(0, 1));
        bif.bypass_packet[l].data  = $urandom;
      end
      for (int s = 0; s < NS; s++) begin
        bif.src_valid[s] = 1'($urandom_range(0, 1));
        bif.phy_src[s]   = 7'($urandom_range(0, 7));
        bif.rf_data[s]   = $urandom;
      end
      bif.flush = ($urandom_range(0, 19) == 0);
      bif.hold  = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    // Asynchronous reset mid-stream.
    clear_inputs(); set_pkt(1, 7'h03, 32'h333); req(0, 7'h03, 32'h0); req(1, 7'h03, 32'h0);
    step("pre_async");
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async");
    set_pkt(0, 7'h03, 32'h444); req(0, 7'h03, 32'h0);
    @(posedge clk);
    #1;
    check_outputs("async_edge");
    #2 reset = 1'b1;
    clear_inputs(); req(0, 7'h03, 32'h5A5A);
    step("post_reset");
    check("tp_post_reset_hs", 32'(bif.hit_stage[0]), 32'd0);
    check("tp_post_reset_data", bif.data[0], 32'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bypass_history_nd.md
# bypass_history_nd

Parametrised multi-port, multi-depth operand bypass network for the register-read stage. It keeps a DEPTH-cycle shift history of every lane's bypass packet alongside the live packets. Each of NUM_SRC source operands is resolved against live plus history, and falls back to register-file data when nothing matches. Results are registered, with hold and flush support. It sits between the physical register file read and the execute-stage operand latches, and replaces the single-source, live-only bypass mux.

## Interface
- NUM_LANES, default `ISSUE_WIDTH: bypass packets per cycle.
- DEPTH, default 2: cycles of bypass history retained (1..4).
- NUM_SRC, default 2: source operands resolved in parallel.
- HS_W, derived, $clog2(DEPTH+2): hit-stage code width.
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately.
- bypassPacket_i  in  bypassPkt[NUM_LANES]  live packets (.tag, .valid, .data).
- flush_i  in  1  squash: clear history, drop requests.
- hold_i  in  1  freeze output registers.
- srcValid_i  in  [NUM_SRC]  request valid per source.
- phySrc_i  in  [NUM_SRC][`SIZE_PHYSICAL_LOG]  source tag.
- rfData_i  in  [NUM_SRC][`SIZE_DATA]  register-file read data.
- data_o  out  [NUM_SRC][`SIZE_DATA]  resolved operand (registered).
- valid_o  out  [NUM_SRC]  operand valid (registered).
- hitStage_o  out  [NUM_SRC][HS_W]  match source: 0 = register file, 1 = live, k+2 = history entry k.

## Operation
- History hist[0..DEPTH-1]: hist[0] holds the previous cycle's packets; hist[k] holds packets from k+1 cycles ago.
- Each cycle, hist[0] takes bypassPacket_i and hist[k] takes hist[k-1]. The shift runs regardless of hold_i.
- Match for source s: tag equal and packet valid. srcValid_i does not gate the match.
- Priority, youngest first: live stage over hist[0] over … over hist[DEPTH-1].
- Within one stage, the highest-index matching lane wins.
- No match: select rfData_i[s] with hitStage 0.
- Flush_i high at a clock edge:
  - All hist valid bits clear.
  - Live packets of that cycle are not captured.
  - valid_o clears for the next cycle and data_o keeps its value.
- hold_i high without flush_i: data_o, valid_o and hitStage_o keep their values and requests are ignored.
- flush_i has priority over hold_i.
- Otherwise: valid_o[s] <= srcValid_i[s]. data_o and hitStage_o update for every s, valid or not.
- Reset low:
  - hist valid, data_o, valid_o and hitStage_o all clear to 0.
  - Request or packet inputs during reset have no effect.
  - After deassertion, behaviour is as after a flush.

## Timing
- Latency: request at cycle t, result visible at cycle t+1.
- A producer broadcasting at cycle t is visible to consumers requesting at cycles t through t+DEPTH.
- A consumer requesting at cycle t+DEPTH+1 or later must get the value from the register file.
- Same tag from two stages (a rename tag reused after commit): the younger stage wins.
- Same tag on two lanes of one stage is illegal upstream. If it happens, the higher lane wins deterministically.
- Combinational path: NUM_LANES × (DEPTH+1) comparators per source, then the priority mux, then the output register. There is no input-to-output combinational path.

## Structure
- A shared package holds bypassPkt (already global), the HS_W helper, and the DEPTH bound check.
- Sub-module bypass_match_stage: one stage's lanes against one tag. Outputs hit, winning lane data, and highest-lane priority.
- The top level instantiates NUM_SRC × (DEPTH+1) of these, plus the history shift registers and output registers.
- Parameter legality (DEPTH < 1 or > 4) is checked by an elaboration-time assertion.

## Test plan
- Reset, and basic bypass from each stage:
  - Reset held low for 3 cycles → all outputs 0.
  - Release. Lane 2 broadcasts tag 0x15, data 0xAAAA, at cycle 5. Source 0 requests 0x15 with rfData 0x1111:
    - request at cycle 5 → cycle 6 gives data 0xAAAA, hitStage 1;
    - request at cycle 6 → hitStage 2;
    - request at cycle 7 (DEPTH=2) → hitStage 3;
    - request at cycle 8 → 0x1111, hitStage 0.
- Age priority:
  - Tag 0x20 broadcast with 0x1 at cycle 10 and with 0x2 at cycle 11.
  - Request at cycle 11 → 0x2, hitStage 1.
  - Request at cycle 12 → 0x2, hitStage 2.
- Lane priority:
  - Lanes 0 and 3 both carry tag 0x7 in one cycle, with 0xB0 and 0xB3.
  - Same-cycle request → 0xB3.
- Flush:
  - Tag 0x9 broadcast at cycle 20, flush_i high at cycle 21, request at cycle 21 → valid_o 0 at cycle 22.
  - Request at cycle 22 → rfData, hitStage 0.
- Hold:
  - Output showing 0x55 with valid 1. Hold for 4 cycles while requests change → outputs constant.
  - History keeps aging during the hold: a packet broadcast at hold start is not visible after 3+ cycles of hold.
- Asynchronous reset mid-stream:
  - Drop reset between edges during active bypassing → outputs go 0 immediately, without a clock edge.
  - First request after release → hitStage 0.
